// File: rtl/rgb_breathe_pkg.sv
// Shared mode codes and FSM state encoding for the N-channel breathing-LED engine.
package rgb_breathe_pkg;

  localparam logic [1:0] MODE_OFF           = 2'd0;
  localparam logic [1:0] MODE_STEADY        = 2'd1;
  localparam logic [1:0] MODE_BREATHE_FIXED = 2'd2;
  localparam logic [1:0] MODE_BREATHE_CYCLE = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RISE      = 3'd1,
    ST_HOLD_HI   = 3'd2,
    ST_FALL      = 3'd3,
    ST_HOLD_LO   = 3'd4,
    ST_STEADY_ON = 3'd5
  } state_e;

endpackage

// File: rtl/breathe_prescaler.sv
// Ramp-tick prescaler: counts 0..PRESCALE_DIV-1 and flags the last count as a tick.
module breathe_prescaler #(
  parameter int unsigned PRESCALE_DIV = 300000,
  parameter int unsigned PRESCALE_W   = 24
) (
  input  logic clki,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam logic [PRESCALE_W-1:0] PRE_LAST = PRESCALE_W'(PRESCALE_DIV - 1);

  logic [PRESCALE_W-1:0] pre_cnt_q;

  assign tick = (pre_cnt_q == PRE_LAST);

  // clr restarts the ramp phase so a new mode always begins on a full tick period
  always_ff @(posedge clki) begin
    if (rst || clr) begin
      pre_cnt_q <= '0;
    end else if (tick) begin
      pre_cnt_q <= '0;
    end else begin
      pre_cnt_q <= pre_cnt_q + PRESCALE_W'(1);
    end
  end

endmodule

// File: rtl/rgb_breathe_seq.sv
// N-channel breathing-LED engine: shared intensity ramp with peak/valley holds,
// optional colour-mask stepping, and registered PWM enables for the RGB driver.
module rgb_breathe_seq
  import rgb_breathe_pkg::*;
#(
  parameter int unsigned NUM_CH       = 3,
  parameter int unsigned PWM_W        = 8,
  parameter int unsigned PRESCALE_DIV = 300000,
  parameter int unsigned PRESCALE_W   = 24,
  parameter int unsigned HOLD_TICKS   = 16
) (
  input  logic              clki,
  input  logic              rst,
  input  logic [1:0]        mode_i,
  input  logic [NUM_CH-1:0] color_sel_i,
  output logic [NUM_CH-1:0] pwm_o,
  output logic [PWM_W-1:0]  level_o,
  output logic              seq_wrap_o
);

  localparam int unsigned       HOLD_W      = (HOLD_TICKS < 1) ? 1 : $clog2(HOLD_TICKS + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(HOLD_TICKS);
  localparam logic [PWM_W-1:0]  LVL_MAX     = '1;
  localparam logic [PWM_W-1:0]  LVL_ONE     = PWM_W'(1);
  localparam logic [PWM_W-1:0]  LVL_PRE_MAX = LVL_MAX - LVL_ONE;
  localparam logic [NUM_CH-1:0] COLOR_FIRST = NUM_CH'(1);
  localparam logic [NUM_CH-1:0] COLOR_LAST  = '1;

  logic [1:0]        mode_q;
  state_e            state_q;
  logic [PWM_W-1:0]  level_q;
  logic [HOLD_W-1:0] hold_cnt_q;
  logic [NUM_CH-1:0] color_idx_q;
  logic [NUM_CH-1:0] color_idx_d;
  logic              seq_wrap_q;
  logic [PWM_W-1:0]  pwm_cnt_q;
  logic [NUM_CH-1:0] pwm_q;
  logic [NUM_CH-1:0] mask_c;
  logic              mode_chg_c;
  logic              hold_done_c;
  logic              tick;

  assign mode_chg_c  = (mode_i != mode_q);
  assign hold_done_c = (hold_cnt_q == HOLD_LAST);
  assign color_idx_d = (color_idx_q == COLOR_LAST) ? COLOR_FIRST : color_idx_q + NUM_CH'(1);

  breathe_prescaler #(
    .PRESCALE_DIV (PRESCALE_DIV),
    .PRESCALE_W   (PRESCALE_W)
  ) u_prescaler (
    .clki (clki),
    .rst  (rst),
    .clr  (mode_chg_c),
    .tick (tick)
  );

  // Channel mask: live colour select in fixed modes, stepped index in cycle mode
  always_comb begin
    mask_c = '0;
    case (mode_q)
      MODE_STEADY, MODE_BREATHE_FIXED: mask_c = color_sel_i;
      MODE_BREATHE_CYCLE:              mask_c = color_idx_q;
      default:                         mask_c = '0;
    endcase
  end

  // Breathing FSM; a mode change or OFF forces IDLE ahead of any tick
  always_ff @(posedge clki) begin
    if (rst) begin
      mode_q      <= MODE_OFF;
      state_q     <= ST_IDLE;
      level_q     <= '0;
      hold_cnt_q  <= '0;
      color_idx_q <= COLOR_FIRST;
      seq_wrap_q  <= 1'b0;
    end else begin
      mode_q     <= mode_i;
      seq_wrap_q <= 1'b0;
      if (mode_chg_c || (mode_q == MODE_OFF)) begin
        state_q    <= ST_IDLE;
        level_q    <= '0;
        hold_cnt_q <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (mode_q == MODE_STEADY) begin
              state_q <= ST_STEADY_ON;
              level_q <= LVL_MAX;
            end else begin
              state_q <= ST_RISE;
            end
          end
          ST_RISE: if (tick) begin
            level_q <= level_q + LVL_ONE;
            if (level_q == LVL_PRE_MAX) state_q <= ST_HOLD_HI;
          end
          ST_HOLD_HI: if (tick) begin
            if (hold_done_c) begin
              hold_cnt_q <= '0;
              state_q    <= ST_FALL;
            end else begin
              hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
            end
          end
          ST_FALL: if (tick) begin
            level_q <= level_q - LVL_ONE;
            if (level_q == LVL_ONE) state_q <= ST_HOLD_LO;
          end
          ST_HOLD_LO: if (tick) begin
            if (hold_done_c) begin
              hold_cnt_q <= '0;
              state_q    <= ST_RISE;
              if (mode_q == MODE_BREATHE_CYCLE) begin
                color_idx_q <= color_idx_d;
                seq_wrap_q  <= (color_idx_q == COLOR_LAST);
              end
            end else begin
              hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
            end
          end
          ST_STEADY_ON: level_q <= LVL_MAX;
          default: begin
            state_q <= ST_IDLE;
            level_q <= '0;
          end
        endcase
      end
    end
  end

  // Free-running PWM counter and registered compare
  always_ff @(posedge clki) begin
    if (rst) begin
      pwm_cnt_q <= '0;
      pwm_q     <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + LVL_ONE;
      pwm_q     <= (pwm_cnt_q < level_q) ? mask_c : '0;
    end
  end

  assign pwm_o      = pwm_q;
  assign level_o    = level_q;
  assign seq_wrap_o = seq_wrap_q;

endmodule

// File: tb/tb_rgb_breathe_seq.sv
// Directed bench for rgb_breathe_seq with a short prescaler and 4-bit PWM.
module tb_rgb_breathe_seq;

  localparam int unsigned NUM_CH       = 3;
  localparam int unsigned PWM_W        = 4;
  localparam int unsigned PRESCALE_DIV = 4;
  localparam int unsigned PRESCALE_W   = 4;
  localparam int unsigned HOLD_TICKS   = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        mode_i;
  logic [NUM_CH-1:0] color_sel_i;
  logic [NUM_CH-1:0] pwm_o;
  logic [PWM_W-1:0]  level_o;
  logic              seq_wrap_o;

  int checks = 0;
  int errors = 0;

  rgb_breathe_seq #(
    .NUM_CH       (NUM_CH),
    .PWM_W        (PWM_W),
    .PRESCALE_DIV (PRESCALE_DIV),
    .PRESCALE_W   (PRESCALE_W),
    .HOLD_TICKS   (HOLD_TICKS)
  ) dut (
    .clki        (clk),
    .rst         (rst),
    .mode_i      (mode_i),
    .color_sel_i (color_sel_i),
    .pwm_o       (pwm_o),
    .level_o     (level_o),
    .seq_wrap_o  (seq_wrap_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input logic [1:0] m, input logic [2:0] s);
    rst = 1'b1; mode_i = m; color_sel_i = s;
    repeat (3) step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; mode_i = 2'd2; color_sel_i = 3'b101;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (pwm_o !== 3'b000 || level_o !== 4'd0 || seq_wrap_o !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold: pwm=%b level=%0d wrap=%b, required 000/0/0", pwm_o, level_o, seq_wrap_o);
      end
    end
    rst = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step();
      if (k == 4) begin
        checks++;
        if (level_o !== 4'd0) begin errors++; $display("FAIL reset_level_k4: level=%0d, required 0", level_o); end
      end
      if (k == 5) begin
        checks++;
        if (level_o !== 4'd1) begin errors++; $display("FAIL reset_level_k5: level=%0d, required 1", level_o); end
      end
    end
  endtask

  task automatic test_ramp();
    int ones0 = 0, ones1 = 0, ones2 = 0;
    apply_reset(2'd2, 3'b101);
    for (int k = 1; k <= 133; k++) begin
      step();
      if (pwm_o[1]) ones1++;
      if (k >= 62 && k <= 77) begin
        if (pwm_o[0]) ones0++;
        if (pwm_o[2]) ones2++;
      end
      if (k == 60 || k == 61 || k == 76 || k == 77 || k == 132 || k == 133) begin
        logic [3:0] exp_lvl;
        case (k)
          60:      exp_lvl = 4'd14;
          61:      exp_lvl = 4'd15;
          76:      exp_lvl = 4'd15;
          77:      exp_lvl = 4'd14;
          132:     exp_lvl = 4'd1;
          default: exp_lvl = 4'd0;
        endcase
        checks++;
        if (level_o !== exp_lvl) begin
          errors++;
          $display("FAIL ramp_level_k%0d: level=%0d, required %0d", k, level_o, exp_lvl);
        end
      end
    end
    checks++;
    if (ones1 !== 0) begin errors++; $display("FAIL ramp_pwm1_masked: ones=%0d, required 0", ones1); end
    checks++;
    if (ones0 !== 15) begin errors++; $display("FAIL peak_duty_ch0: ones=%0d/16, required 15", ones0); end
    checks++;
    if (ones2 !== 15) begin errors++; $display("FAIL peak_duty_ch2: ones=%0d/16, required 15", ones2); end
  endtask

  task automatic test_mode_change();
    int ones0 = 0, ones1 = 0, ones2 = 0, bad = 0;
    apply_reset(2'd2, 3'b110);
    repeat (38) step();
    checks++;
    if (level_o !== 4'd9) begin errors++; $display("FAIL chg_pre_level: level=%0d, required 9", level_o); end
    mode_i = 2'd1;
    step();
    checks++;
    if (level_o !== 4'd0) begin errors++; $display("FAIL chg_idle_level: level=%0d, required 0", level_o); end
    step();
    checks++;
    if (level_o !== 4'd15) begin errors++; $display("FAIL chg_steady_level: level=%0d, required 15", level_o); end
    for (int i = 0; i < 16; i++) begin
      step();
      if (pwm_o[0]) ones0++;
      if (pwm_o[1]) ones1++;
      if (pwm_o[2]) ones2++;
    end
    checks++;
    if (ones0 !== 0 || ones1 !== 15 || ones2 !== 15) begin
      errors++;
      $display("FAIL steady_duty_110: ones=%0d/%0d/%0d, required 0/15/15", ones0, ones1, ones2);
    end
    color_sel_i = 3'b011;
    ones0 = 0; ones2 = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (pwm_o[0]) ones0++;
      if (pwm_o[2]) ones2++;
    end
    checks++;
    if (ones0 !== 15 || ones2 !== 0) begin
      errors++;
      $display("FAIL steady_live_sel: ones0=%0d ones2=%0d, required 15/0", ones0, ones2);
    end
    mode_i = 2'd2;
    for (int k = 1; k <= 5; k++) begin
      step();
      if (k == 4) begin
        checks++;
        if (level_o !== 4'd0) begin errors++; $display("FAIL prescale_restart_k4: level=%0d, required 0", level_o); end
      end
      if (k == 5) begin
        checks++;
        if (level_o !== 4'd1) begin errors++; $display("FAIL prescale_restart_k5: level=%0d, required 1", level_o); end
      end
    end
    repeat (10) step();
    mode_i = 2'd0;
    step();
    checks++;
    if (level_o !== 4'd0) begin errors++; $display("FAIL off_level: level=%0d, required 0", level_o); end
    step();
    checks++;
    if (pwm_o !== 3'b000) begin errors++; $display("FAIL off_pwm: pwm=%b, required 000", pwm_o); end
    for (int i = 0; i < 20; i++) begin
      step();
      if (pwm_o !== 3'b000 || level_o !== 4'd0) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL off_stays_dark: bad_cycles=%0d, required 0", bad); end
  endtask

  task automatic test_rst_mid_fall();
    apply_reset(2'd2, 3'b111);
    repeat (100) step();
    checks++;
    if (level_o !== 4'd9) begin errors++; $display("FAIL fall_level: level=%0d, required 9", level_o); end
    rst = 1'b1;
    step();
    checks++;
    if (pwm_o !== 3'b000 || level_o !== 4'd0 || seq_wrap_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_fall: pwm=%b level=%0d wrap=%b, required 000/0/0", pwm_o, level_o, seq_wrap_o);
    end
    rst = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step();
      if (k == 4) begin
        checks++;
        if (level_o !== 4'd0) begin errors++; $display("FAIL rst_restart_k4: level=%0d, required 0", level_o); end
      end
      if (k == 5) begin
        checks++;
        if (level_o !== 4'd1) begin errors++; $display("FAIL rst_restart_k5: level=%0d, required 1", level_o); end
      end
    end
  endtask

  task automatic test_cycle();
    logic [2:0] acc [8];
    logic [2:0] exp_col;
    int wraps = 0, wrap_k = 0;
    for (int b = 0; b < 8; b++) acc[b] = 3'b000;
    apply_reset(2'd3, 3'b000);
    for (int k = 1; k <= 1100; k++) begin
      step();
      if (seq_wrap_o) begin wraps++; wrap_k = k; end
      for (int b = 0; b < 8; b++) begin
        if (k >= 62 + 144 * b && k <= 77 + 144 * b) acc[b] = acc[b] | pwm_o;
      end
    end
    for (int b = 0; b < 8; b++) begin
      exp_col = 3'((b % 7) + 1);
      checks++;
      if (acc[b] !== exp_col) begin
        errors++;
        $display("FAIL cycle_color_b%0d: mask=%b, required %b", b, acc[b], exp_col);
      end
    end
    checks++;
    if (wraps !== 1 || wrap_k !== 1009) begin
      errors++;
      $display("FAIL cycle_wrap: pulses=%0d at cycle %0d, required 1 at 1009", wraps, wrap_k);
    end
  endtask

  initial begin
    rst = 1'b1; mode_i = 2'd0; color_sel_i = 3'b000;
    test_reset();
    test_ramp();
    test_mode_change();
    test_rst_mid_fall();
    test_cycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
